// File: rtl/if_fetch_unit_pkg.sv
// Core-wide constants shared by fetch, decode and exception logic.
package if_fetch_unit_pkg;

  localparam logic [31:0] ResetPc      = 32'hbfc0_0000;
  localparam logic [31:0] ExcVecBev    = 32'hbfc0_0380;
  localparam logic [31:0] ExcVecNormal = 32'h8000_0180;
  localparam logic [31:0] NopInst      = 32'h0000_0000;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/if_fetch_unit_inst_hold_buf.sv
// One-entry skid register for an SRAM read word, plus the decode-side output mux.
module inst_hold_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        capture_i,
  input  logic        sel_hold_i,
  input  logic        kill_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);

  logic [31:0] hold_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
    end else if (capture_i) begin
      hold_q <= rdata_i;
    end
  end

  always_comb begin
    inst_o = rdata_i;
    if (kill_i) begin
      inst_o = NOP_INST;
    end else if (sel_hold_i) begin
      inst_o = hold_q;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, synchronous I-SRAM interface and a
// stall-absorbing hold buffer in front of decode.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPc,
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic [31:0] pc_next_i,
  output logic [31:0] pc_f_o,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] pc_d_o,
  output logic [31:0] inst_d_o,
  output logic        valid_d_o,
  output logic        adel_d_o
);

  typedef enum logic {StStream, StHold} fetch_state_e;

  fetch_state_e state_q;
  logic [31:0]  pc_f_q, pc_d_q;
  logic         valid_d_q, adel_d_q;
  logic         capture;

  // Buffer the decode word only when a real instruction is about to be
  // lost to the SRAM re-reading pc_f during the stall.
  assign capture = (state_q == StStream) & stall_i & valid_d_q & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StStream;
      pc_f_q    <= RESET_PC;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
      adel_d_q  <= 1'b0;
    end else if (flush_i) begin
      state_q   <= StStream;
      pc_f_q    <= flush_pc_i;
      valid_d_q <= 1'b0;
      adel_d_q  <= 1'b0;
    end else if (stall_i) begin
      if (capture) begin
        state_q <= StHold;
      end
    end else begin
      state_q   <= StStream;
      pc_f_q    <= pc_next_i;
      pc_d_q    <= pc_f_q;
      valid_d_q <= 1'b1;
      adel_d_q  <= pc_misaligned(pc_f_q);
    end
  end

  inst_hold_buf #(
    .NOP_INST (NOP_INST)
  ) u_hold_buf (
    .clk        (clk),
    .resetn     (resetn),
    .capture_i  (capture),
    .sel_hold_i (state_q == StHold),
    .kill_i     (~valid_d_q | adel_d_q),
    .rdata_i    (inst_sram_rdata),
    .inst_o     (inst_d_o)
  );

  assign pc_f_o          = pc_f_q;
  assign inst_sram_addr  = pc_f_q;
  assign inst_sram_en    = resetn & ~pc_misaligned(pc_f_q);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;
  assign pc_d_o          = pc_d_q;
  assign valid_d_o       = valid_d_q;
  assign adel_d_o        = adel_d_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue of expected decode pairs.
module tb_if_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] pc_next_i;
  logic [31:0] pc_f_o;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] pc_d_o;
  logic [31:0] inst_d_o;
  logic        valid_d_o;
  logic        adel_d_o;

  logic        use_ovr;
  logic [31:0] ovr_pc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];

  if_fetch_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .pc_next_i       (pc_next_i),
    .pc_f_o          (pc_f_o),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .pc_d_o          (pc_d_o),
    .inst_d_o        (inst_d_o),
    .valid_d_o       (valid_d_o),
    .adel_d_o        (adel_d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: mem[addr] = ~addr, one-cycle read latency.
  initial inst_sram_rdata = 32'h0;
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ 32'hffff_ffff;
  end

  always_comb begin
    pc_next_i = pc_f_o + 32'd4;
    if (use_ovr) pc_next_i = ovr_pc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic valid,
                      input logic adel);
    exp_t e;
    e.tag   = tag;
    e.pc    = pc;
    e.valid = valid;
    e.adel  = adel;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t        e;
    logic [31:0] inst;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e    = exp_q.pop_front();
      inst = (e.valid && !e.adel) ? (e.pc ^ 32'hffff_ffff) : 32'h0;
      chk({e.tag, "_valid"}, {31'd0, valid_d_o}, {31'd0, e.valid});
      chk({e.tag, "_adel"},  {31'd0, adel_d_o},  {31'd0, e.adel});
      chk({e.tag, "_inst"},  inst_d_o, inst);
      if (e.valid) chk({e.tag, "_pc"}, pc_d_o, e.pc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    use_ovr    = 1'b0;
    ovr_pc     = 32'h0;

    tick();
    chk("rst_en",    {31'd0, inst_sram_en}, 32'd0);
    chk("rst_pc_f",  pc_f_o, 32'hbfc0_0000);
    chk("rst_pc_d",  pc_d_o, 32'h0);
    chk("rst_valid", {31'd0, valid_d_o}, 32'd0);
    chk("rst_inst",  inst_d_o, 32'h0);
    chk("rst_wen",   {28'd0, inst_sram_wen}, 32'd0);

    resetn = 1'b1;
    #1;
    chk("first_en",   {31'd0, inst_sram_en}, 32'd1);
    chk("first_addr", inst_sram_addr, 32'hbfc0_0000);

    // Streaming
    push("s0", 32'hbfc0_0000, 1'b1, 1'b0); tick(); pop_chk();
    chk("s0_inst_lit", inst_d_o, 32'h403f_ffff);
    push("s1", 32'hbfc0_0004, 1'b1, 1'b0); tick(); pop_chk();
    chk("s1_inst_lit", inst_d_o, 32'h403f_fffb);
    push("s2", 32'hbfc0_0008, 1'b1, 1'b0); tick(); pop_chk();

    // Three-cycle stall holding bfc00008
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("stall", 32'hbfc0_0008, 1'b1, 1'b0); tick(); pop_chk();
    end
    chk("stall_pc_f", pc_f_o, 32'hbfc0_000c);
    stall_i = 1'b0;
    push("rel0", 32'hbfc0_000c, 1'b1, 1'b0); tick(); pop_chk();
    push("rel1", 32'hbfc0_0010, 1'b1, 1'b0); tick(); pop_chk();

    // Flush while streaming
    flush_i    = 1'b1;
    flush_pc_i = 32'hbfc0_0380;
    push("flush", 32'h0, 1'b0, 1'b0); tick(); pop_chk();
    chk("flush_pc_f", pc_f_o, 32'hbfc0_0380);
    flush_i = 1'b0;
    push("fl_tgt", 32'hbfc0_0380, 1'b1, 1'b0); tick(); pop_chk();
    push("fl_nxt", 32'hbfc0_0384, 1'b1, 1'b0); tick(); pop_chk();

    // Enter HOLD, then flush and stall together
    stall_i = 1'b1;
    push("hold_a", 32'hbfc0_0384, 1'b1, 1'b0); tick(); pop_chk();
    push("hold_b", 32'hbfc0_0384, 1'b1, 1'b0); tick(); pop_chk();
    flush_i    = 1'b1;
    flush_pc_i = 32'hbfc0_0180;
    push("fl_st", 32'h0, 1'b0, 1'b0); tick(); pop_chk();
    flush_i = 1'b0;
    stall_i = 1'b0;
    push("fl_st_tgt", 32'hbfc0_0180, 1'b1, 1'b0); tick(); pop_chk();
    push("fl_st_nxt", 32'hbfc0_0184, 1'b1, 1'b0); tick(); pop_chk();

    // Misaligned fetch
    use_ovr = 1'b1;
    ovr_pc  = 32'hbfc0_0002;
    push("pre_mis", 32'hbfc0_0188, 1'b1, 1'b0); tick(); pop_chk();
    chk("mis_en",   {31'd0, inst_sram_en}, 32'd0);
    chk("mis_pc_f", pc_f_o, 32'hbfc0_0002);
    ovr_pc = 32'hbfc0_0100;
    push("mis", 32'hbfc0_0002, 1'b1, 1'b1); tick(); pop_chk();
    use_ovr = 1'b0;
    push("post_mis", 32'hbfc0_0100, 1'b1, 1'b0); tick(); pop_chk();

    // Asynchronous reset in the middle of HOLD
    stall_i = 1'b1;
    push("hold_r", 32'hbfc0_0100, 1'b1, 1'b0); tick(); pop_chk();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_pc_f",  pc_f_o, 32'hbfc0_0000);
    chk("arst_pc_d",  pc_d_o, 32'h0);
    chk("arst_valid", {31'd0, valid_d_o}, 32'd0);
    chk("arst_inst",  inst_d_o, 32'h0);
    chk("arst_en",    {31'd0, inst_sram_en}, 32'd0);
    stall_i = 1'b0;
    #1;
    resetn = 1'b1;
    push("post_rst", 32'hbfc0_0000, 1'b1, 1'b0); tick(); pop_chk();
    push("post_rst1", 32'hbfc0_0004, 1'b1, 1'b0); tick(); pop_chk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage for the MIPS core.
- Holds the fetch PC register.
- Drives the synchronous instruction SRAM (1-cycle read latency).
- Delivers a PC/instruction pair to decode.
- Consumes the next-fetch address from the next-PC selector, which sits combinationally between this block's `pc_f_o` and `pc_next_i`.
- Absorbs decode stalls with a one-entry instruction hold buffer, and redirects on pipeline flush (exception/eret).

## Interface
Parameters:
- `RESET_PC`, `32'hbfc0_0000`, first fetch address after reset.
- `NOP_INST`, `32'h0000_0000`, instruction presented when the output is invalid.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `stall_i` in 1: decode cannot accept; hold the fetch PC and the output pair.
- `flush_i` in 1: redirect the fetch to `flush_pc_i` and kill the output pair.
- `flush_pc_i` in 32: redirect target (exception vector or EPC).
- `pc_next_i` in 32: next fetch address from the next-PC selector.
- `pc_f_o` out 32: current fetch PC (feeds the next-PC selector).
- `inst_sram_en` out 1: SRAM read enable.
- `inst_sram_wen` out 4: tied to `4'b0000`.
- `inst_sram_addr` out 32: equals `pc_f_o`.
- `inst_sram_wdata` out 32: tied to 0.
- `inst_sram_rdata` in 32: read data, valid the cycle after the address is issued.
- `pc_d_o` out 32: PC of the instruction handed to decode.
- `inst_d_o` out 32: instruction handed to decode.
- `valid_d_o` out 1: the output pair is a real instruction.
- `adel_d_o` out 1: the fetch address of `pc_d_o` was misaligned (AdEL).

## Operation
Registers:
- `pc_f`: fetch PC.
- `pc_d`: decode PC.
- `valid_d`, `adel_d`: decode-side status bits.
- `hold_inst`: buffered instruction word.
- `state`: one of `STREAM` or `HOLD`.

Address path:
- `inst_sram_addr = pc_f`.
- `inst_sram_en = resetn & (pc_f[1:0]==2'b00)`.

Normal advance (no stall, no flush):
- `pc_f <= pc_next_i`
- `pc_d <= pc_f`
- `valid_d <= 1`
- `adel_d <= |pc_f[1:0]`

Output mux:
- `inst_d_o` = `NOP_INST` if `!valid_d` or `adel_d`.
- Otherwise `hold_inst` in `HOLD`.
- Otherwise `inst_sram_rdata` in `STREAM`.

FSM:
- `STREAM` → `HOLD` when `stall_i & valid_d & !flush_i`. Capture `hold_inst <= inst_sram_rdata` (the word for `pc_d`, which is about to be overwritten by a re-read of `pc_f`).
- `HOLD` stays while `stall_i & !flush_i`; `hold_inst` does not change.
- `HOLD` → `STREAM` on the first non-stall cycle. The pair (`pc_d`, `hold_inst`) is consumed, and the normal advance occurs in that same cycle. Because `pc_f` was re-read during the stall, next-cycle `rdata` is the word for the new `pc_d`.
- While stalled, `pc_f`, `pc_d`, `valid_d` and `adel_d` all hold. The SRAM keeps reading `pc_f`.

Flush (priority over stall):
- `pc_f <= flush_pc_i`
- `valid_d <= 0`
- `adel_d <= 0`
- `state <= STREAM`
- `flush_pc_i` is issued to the SRAM in the next cycle.

Misaligned PC:
- No SRAM access.
- The pair still flows to decode with `adel_d_o=1` and `inst_d_o=NOP_INST`.
- The next fetch is still `pc_next_i`; the exception unit flushes.

## Timing
- Reset values: `pc_f=RESET_PC`, `pc_d=0`, `valid_d=0`, `adel_d=0`, `hold_inst=0`, `state=STREAM`. `inst_sram_en=0` while `resetn=0`.
- First cycle after reset release: `RESET_PC` is issued. The next cycle shows `pc_d_o=RESET_PC`, `valid_d_o=1`, and the SRAM word.
- Fetch-to-decode latency is 1 cycle. Throughput is 1 instruction per cycle without stalls.
- A flush asserted in cycle n gives `valid_d_o=0` in cycle n+1 and `pc_d_o=flush_pc_i` with `valid=1` in cycle n+2.
- Simultaneous `flush_i` and `stall_i`: the flush wins.
- Reset asserted mid-stall: all registers take their reset values asynchronously, and the `HOLD` contents are discarded.
- `stall_i` while `valid_d=0`: `pc_f` holds and the FSM stays in `STREAM` (nothing to buffer).

## Structure
- A shared core package holds `RESET_PC`, the exception vector constants and `NOP_INST`. `NOP_INST` is used by decode and exception logic too.
- The FSM encoding (`STREAM`/`HOLD`) is local to this block.
- Sub-module: `inst_hold_buf` (one-entry skid register plus output mux). It is natural to separate it and reuse it in the data-side load path.
- The next-PC selector stays a separate combinational block.

## Test plan
- Reset release, SRAM returns `mem[addr]=addr^32'hffff_ffff`, `pc_next_i=pc_f_o+4`: pairs `bfc00000/403fffff`, `bfc00004/403ffffb`, … one per cycle, `valid=1`.
- Stall for 3 cycles with `pc_d_o=bfc00008`: `pc_d_o`, `inst_d_o` and `valid_d_o` stay constant for all 3 cycles. The cycle after release shows `pc_d_o=bfc0000c` with the correct word; no duplicate or skipped instruction.
- Flush to `bfc00380` while streaming: the next cycle has `valid_d_o=0`; the following cycle has `pc_d_o=bfc00380`.
- Flush and stall asserted together while in `HOLD`: the flush takes effect, the FSM returns to `STREAM`, and the held instruction is never presented again.
- `pc_next_i=bfc00002`: `inst_sram_en=0` in the fetch cycle. The next cycle shows `pc_d_o=bfc00002`, `adel_d_o=1`, `inst_d_o=0`.
- Assert `resetn=0` asynchronously mid-`HOLD`: outputs return to reset values immediately without a clock edge.
